// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: MCU control unit. Owns the LOAD/FETCH/DECODE/EXECUTE stage
// FSM, the counted program load, DMEM operand wait states and the UART rx/tx
// handshakes with a forced-advance timeout. Drives every datapath enable.
// Optional HALT instruction (IR=14'h00FF) and `halted` port: define CTRL_SEQ_HALT_EN.
module ctrl_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DMEM_WAIT  = 0,
  parameter int TMO_W      = 8,
  parameter int IO_TIMEOUT = 200
) (
  input  logic              rx_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              rx_done,
  input  logic              tx_done,
  input  logic              rx_PC_E,
  input  logic [13:0]       IR,
  input  logic [3:0]        SR,
  output logic [1:0]        stage,
  output logic              busy,
  output logic              io_timeout,
  output logic              PC_E,
  output logic              Acc_E,
  output logic              SR_E,
  output logic              IR_E,
  output logic              DR_E,
  output logic              PMEM_E,
  output logic              PMEM_LE,
  output logic              DMEM_E,
  output logic              DMEM_WE,
  output logic              COMP_E,
  output logic              ALU_E,
  output logic              MUX1_Sel,
  output logic              MUX2_Sel,
  output logic              MUX3_sel,
  output logic              rx_reset,
  output logic              tx_reset,
  output logic              tx_ready,
  output logic [3:0]        ALU_Mode
`ifdef CTRL_SEQ_HALT_EN
  ,
  output logic              halted
`endif
);

  typedef enum logic [1:0] {S_LOAD = 2'b00, S_FETCH = 2'b01, S_DECODE = 2'b10, S_EXEC = 2'b11} state_t;

  localparam logic [3:0]       LP_WAIT     = 4'(DMEM_WAIT);
  localparam logic [TMO_W-1:0] LP_TMO_LAST = TMO_W'(IO_TIMEOUT - 1);

  state_t            r_state, w_next;
  logic              r_armed, w_armed_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]        r_wait, w_wait_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              w_mtype, w_io_done, w_tmo_hit, w_load_last, w_halt_now;

  assign w_mtype     = ~IR[13] & (IR[11:9] == 3'b001);
  assign w_io_done   = IR[12] ? rx_PC_E : tx_done;
  assign w_tmo_hit   = (r_tmo == LP_TMO_LAST) & ~w_io_done;
  // Compare one bit wider so load_len = all-ones cannot alias on count+1.
  assign w_load_last = ({1'b0, r_cnt} + 1'b1) == {1'b0, load_len};
  assign stage       = r_state;

`ifdef CTRL_SEQ_HALT_EN
  logic r_halted;
  assign w_halt_now = r_halted | ((r_state == S_EXEC) & (IR == 14'h00FF));
  assign halted     = w_halt_now;

  // Halt is sticky until reset.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) r_halted <= 1'b0;
    else if (w_halt_now) r_halted <= 1'b1;
  end
`else
  logic w_unused_ir;
  assign w_halt_now  = 1'b0;
  assign w_unused_ir = ^IR[3:0];
`endif

  // State and counter registers.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      r_armed <= w_armed_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wait  <= w_wait_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Next-state logic and datapath enables; all outputs idle while in reset.
  always_comb begin
    w_next      = r_state;
    w_armed_nxt = r_armed;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = r_wait;
    w_tmo_nxt   = r_tmo;
    {PC_E, Acc_E, SR_E, IR_E, DR_E, PMEM_E, PMEM_LE, DMEM_E, DMEM_WE} = '0;
    {COMP_E, ALU_E, MUX1_Sel, MUX2_Sel, MUX3_sel, tx_ready, busy, io_timeout} = '0;
    ALU_Mode = 4'd0;
    rx_reset = 1'b1;
    tx_reset = 1'b1;
    if (rst_n) begin
      unique case (r_state)
        S_LOAD: begin
          if (!r_armed) begin
            if (start) begin
              if (load_len != '0) w_armed_nxt = 1'b1;
              else                w_next      = S_FETCH;
            end
          end else begin
            PMEM_LE  = 1'b1;
            PMEM_E   = 1'b1;
            rx_reset = 1'b0;
            busy     = 1'b1;
            if (rx_done) begin
              if (w_load_last) begin
                w_next      = S_FETCH;
                w_armed_nxt = 1'b0;
                w_cnt_nxt   = '0;
              end else if (r_cnt != '1) begin
                w_cnt_nxt = r_cnt + 1'b1;
              end
            end
          end
        end
        S_FETCH: begin
          IR_E   = 1'b1;
          PMEM_E = 1'b1;
          w_next = S_DECODE;
        end
        S_DECODE: begin
          if (w_mtype) begin
            DR_E   = 1'b1;
            DMEM_E = 1'b1;
            if (r_wait >= LP_WAIT) begin
              w_wait_nxt = '0;
              w_next     = S_EXEC;
            end else begin
              w_wait_nxt = r_wait + 1'b1;
            end
          end else begin
            w_next = S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_halt_now) begin
            w_next = S_EXEC;
          end else if (IR[13]) begin
            MUX1_Sel = 1'b1;
            DMEM_E   = 1'b1;
            busy     = 1'b1;
            if (IR[12]) begin
              MUX3_sel = 1'b1;
              DMEM_WE  = 1'b1;
              rx_reset = 1'b0;
            end else begin
              DR_E     = 1'b1;
              tx_ready = 1'b1;
              tx_reset = 1'b0;
            end
            if (w_io_done || w_tmo_hit) begin
              PC_E       = 1'b1;
              io_timeout = w_tmo_hit;
              w_tmo_nxt  = '0;
              w_next     = S_FETCH;
            end else if (r_tmo != '1) begin
              w_tmo_nxt = r_tmo + 1'b1;
            end
          end else begin
            PC_E   = 1'b1;
            w_next = S_FETCH;
            if (IR[11]) begin
              Acc_E    = 1'b1;
              SR_E     = 1'b1;
              ALU_E    = 1'b1;
              MUX1_Sel = 1'b1;
              ALU_Mode = {1'b0, IR[10:8]};
            end else if (IR[10]) begin
              MUX1_Sel = SR[IR[9:8]];
            end else if (IR[9]) begin
              SR_E     = 1'b1;
              ALU_E    = 1'b1;
              MUX1_Sel = 1'b1;
              MUX2_Sel = 1'b1;
              Acc_E    = IR[8];
              DMEM_E   = ~IR[8];
              DMEM_WE  = ~IR[8];
              ALU_Mode = IR[7:4];
            end else if (!IR[8]) begin
              MUX1_Sel = 1'b1;
              COMP_E   = IR[4];
            end
          end
        end
        default: w_next = S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed + randomized checks of ctrl_sequencer against a
// per-stage expectation model and arithmetic stage-length predictions.
module tb_ctrl_sequencer;
  localparam int DW  = 2;
  localparam int TMO = 200;

  logic rx_clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] load_len = '0;
  logic rx_done = 1'b0, tx_done = 1'b0, rx_PC_E = 1'b0;
  logic [13:0] IR = '0;
  logic [3:0] SR = '0;
  logic [1:0] stage;
  logic busy, io_timeout, PC_E, Acc_E, SR_E, IR_E, DR_E, PMEM_E, PMEM_LE, DMEM_E, DMEM_WE;
  logic COMP_E, ALU_E, MUX1_Sel, MUX2_Sel, MUX3_sel, rx_reset, tx_reset, tx_ready;
  logic [3:0] ALU_Mode;
  logic [22:0] obs;
  int n_tests = 0, n_fail = 0;

  always #5 rx_clk = ~rx_clk;

  ctrl_sequencer #(.ADDR_W(8), .DMEM_WAIT(DW), .TMO_W(8), .IO_TIMEOUT(TMO)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .rx_done(rx_done), .tx_done(tx_done), .rx_PC_E(rx_PC_E), .IR(IR), .SR(SR),
    .stage(stage), .busy(busy), .io_timeout(io_timeout), .PC_E(PC_E), .Acc_E(Acc_E),
    .SR_E(SR_E), .IR_E(IR_E), .DR_E(DR_E), .PMEM_E(PMEM_E), .PMEM_LE(PMEM_LE),
    .DMEM_E(DMEM_E), .DMEM_WE(DMEM_WE), .COMP_E(COMP_E), .ALU_E(ALU_E),
    .MUX1_Sel(MUX1_Sel), .MUX2_Sel(MUX2_Sel), .MUX3_sel(MUX3_sel),
    .rx_reset(rx_reset), .tx_reset(tx_reset), .tx_ready(tx_ready), .ALU_Mode(ALU_Mode));

  assign obs = {PC_E, Acc_E, SR_E, IR_E, DR_E, PMEM_E, PMEM_LE, DMEM_E, DMEM_WE, COMP_E,
                ALU_E, MUX1_Sel, MUX2_Sel, MUX3_sel, rx_reset, tx_reset, tx_ready, busy,
                io_timeout, ALU_Mode};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected output vector for one cycle, straight from the instruction table.
  function automatic logic [22:0] exp_out(input logic [1:0] stg, input logic armed,
                                          input logic [13:0] ir, input logic [3:0] sr,
                                          input logic done, input logic tmo);
    logic pc, acc, sre, ire, dre, pe, ple, de, dwe, ce, ae, m1, m2, m3, rxr, txr, txq, bz, to;
    logic [3:0] am;
    {pc, acc, sre, ire, dre, pe, ple, de, dwe, ce, ae, m1, m2, m3, txq, bz, to} = '0;
    rxr = 1'b1; txr = 1'b1; am = 4'd0;
    case (stg)
      2'd0: if (armed) begin ple = 1; pe = 1; rxr = 0; bz = 1; end
      2'd1: begin ire = 1; pe = 1; end
      2'd2: if (!ir[13] && ir[11:9] == 3'b001) begin dre = 1; de = 1; end
      default: begin
        if (ir[13:12] == 2'b11) begin
          m3 = 1; de = 1; dwe = 1; m1 = 1; rxr = 0; bz = 1; pc = done | tmo; to = tmo;
        end else if (ir[13:12] == 2'b10) begin
          dre = 1; de = 1; txq = 1; m1 = 1; txr = 0; bz = 1; pc = done | tmo; to = tmo;
        end else if (ir[11]) begin
          pc = 1; acc = 1; sre = 1; ae = 1; m1 = 1; am = {1'b0, ir[10:8]};
        end else if (ir[10]) begin
          pc = 1; m1 = sr[ir[9:8]];
        end else if (ir[9]) begin
          pc = 1; sre = 1; ae = 1; m1 = 1; m2 = 1; acc = ir[8]; de = ~ir[8]; dwe = ~ir[8];
          am = ir[7:4];
        end else if (ir[8]) begin
          pc = 1;
        end else begin
          pc = 1; m1 = 1; ce = ir[4];
        end
      end
    endcase
    return {pc, acc, sre, ire, dre, pe, ple, de, dwe, ce, ae, m1, m2, m3, rxr, txr, txq, bz, to, am};
  endfunction

  // Called at a negedge with inputs already set: check this cycle, advance one clock.
  task automatic cyc(input string tag, input logic [1:0] stg, input logic armed,
                     input logic done, input logic tmo);
    #1;
    chk({tag, "_stage"}, 32'(stage), 32'(stg));
    chk({tag, "_out"}, 32'(obs), 32'(exp_out(stg, armed, IR, SR, done, tmo)));
    @(negedge rx_clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; rx_done = 0; tx_done = 0; rx_PC_E = 0;
    #1;
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_out", 32'(obs), 32'(exp_out(2'd0, 1'b0, 14'h0, 4'h0, 1'b0, 1'b0)));
    @(negedge rx_clk); @(negedge rx_clk);
    rst_n = 1'b1;
  endtask

  // Start a load of len words, one rx_done every gap+1 cycles; a stray start mid-load.
  task automatic do_load(input int len, input int gap);
    start = 1; load_len = 8'(len);
    cyc("ld_start", 2'd0, 1'b0, 1'b0, 1'b0);
    start = 0;
    for (int p = 0; p < len; p++) begin
      for (int g = 0; g < gap; g++) begin
        start = (p == 1 && g == 0);
        cyc("ld_wait", 2'd0, 1'b1, 1'b0, 1'b0);
        start = 0;
      end
      rx_done = 1;
      cyc("ld_pulse", 2'd0, 1'b1, 1'b0, 1'b0);
      rx_done = 0;
    end
  endtask

  // Entered in the FETCH cycle. d = cycles before the I/O handshake arrives.
  task automatic run_instr(input logic [13:0] ir, input logic [3:0] sr, input int d);
    int ndec, nexe;
    logic io, dn, tm;
    IR = ir; SR = sr;
    cyc("fetch", 2'd1, 1'b0, 1'b0, 1'b0);
    ndec = (!ir[13] && ir[11:9] == 3'b001) ? 1 + DW : 1;
    for (int i = 0; i < ndec; i++) cyc("decode", 2'd2, 1'b0, 1'b0, 1'b0);
    io   = ir[13];
    nexe = !io ? 1 : (d < TMO ? d + 1 : TMO);
    for (int k = 0; k < nexe; k++) begin
      dn = io && (k == d);
      tm = io && (k == TMO - 1) && !dn;
      rx_PC_E = dn && ir[12];
      tx_done = dn && !ir[12];
      cyc("exec", 2'd3, 1'b0, dn, tm);
      rx_PC_E = 0; tx_done = 0;
    end
  endtask

  initial begin
    @(negedge rx_clk);
    do_reset();
    // Zero-length load goes straight to FETCH.
    do_load(0, 0);
    run_instr(14'h0B00, 4'h0, 0);
    do_reset();
    do_load(3, 3);
    run_instr(14'h0B00, 4'h0, 0);
    run_instr(14'h0230, 4'h0, 0);
    run_instr(14'h0330, 4'h0, 0);
    run_instr(14'h0500, 4'b0010, 0);
    run_instr(14'h0500, 4'b0000, 0);
    run_instr(14'h0100, 4'hF, 0);
    run_instr(14'h00FF, 4'h0, 0);
    run_instr(14'h2000, 4'h0, 5);
    run_instr(14'h3000, 4'h0, 0);
    run_instr(14'h2000, 4'h0, 1000);
    run_instr(14'h3000, 4'h0, TMO - 1);
    run_instr(14'h3000, 4'h0, 1000);
    for (int n = 0; n < 80; n++)
      run_instr(14'($urandom), 4'($urandom), int'($urandom_range(0, 12)));
    // Reset in the middle of an RX wait.
    IR = 14'h3000;
    cyc("rx_fetch", 2'd1, 1'b0, 1'b0, 1'b0);
    cyc("rx_decode", 2'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc("rx_wait", 2'd3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_stage", 32'(stage), 32'd0);
    chk("midrst_pc", 32'(PC_E), 32'd0);
    chk("midrst_out", 32'(obs), 32'(exp_out(2'd0, 1'b0, 14'h0, 4'h0, 1'b0, 1'b0)));
    @(negedge rx_clk);
    rst_n = 1'b1;
    // Random load lengths and spacings, each followed by one instruction.
    for (int n = 0; n < 4; n++) begin
      do_reset();
      do_load(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
      run_instr(14'($urandom), 4'($urandom), int'($urandom_range(0, 5)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Next-generation microcontroller control unit.
- Owns the LOAD/FETCH/DECODE/EXECUTE stage FSM internally instead of taking the stage as an input.
- Adds a counted program-load phase, configurable data-memory wait states and UART rx/tx handshakes with timeout.
- Sits between the datapath (PC, Acc, SR, IR, DR, PMEM, DMEM, ALU, MUX1-3) and the UART rx/tx blocks; drives every datapath enable.

Parameters:
- ADDR_W, 8: width of program length / load counter.
- DMEM_WAIT, 0: extra DECODE cycles for M-type operand fetch (0..15).
- TMO_W, 8: width of I/O timeout counter.
- IO_TIMEOUT, 200: cycles EXECUTE may wait on rx_PC_E/tx_done before forced advance (1..2^TMO_W-1).

Ports:
- rx_clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin program load.
- load_len  in  ADDR_W  number of program words to load.
- rx_done  in  1  one-cycle pulse per received program/data word.
- tx_done  in  1  one-cycle pulse: tx byte sent.
- rx_PC_E  in  1  rx block: data word stored.
- IR  in  14  instruction register.
- SR  in  4  status flags {O,S,C,Z} indexed by IR[9:8].
- stage  out  2  00 LOAD, 01 FETCH, 10 DECODE, 11 EXECUTE.
- busy  out  1  high while loading or waiting on I/O.
- io_timeout  out  1  one-cycle pulse on forced I/O advance.
- PC_E, Acc_E, SR_E, IR_E, DR_E, PMEM_E, PMEM_LE, DMEM_E, DMEM_WE, COMP_E, ALU_E, MUX1_Sel, MUX2_Sel, MUX3_sel  out  1 each  datapath enables/selects.
- rx_reset, tx_reset  out  1  UART resets, active-high.
- tx_ready  out  1  tx request.
- ALU_Mode  out  4  ALU operation.

Behaviour:
- Reset (rst_n low, async): stage=LOAD, load idle, load count=0, wait count=0, timeout count=0.
  - All enables and selects 0, ALU_Mode=0, tx_ready=0, busy=0, io_timeout=0, rx_reset=tx_reset=1.
  - These outputs are forced combinationally while rst_n is low.
- Outputs are combinational from state and IR. Default every cycle: all 0, rx_reset=tx_reset=1.
- LOAD, idle:
  - Outputs at default.
  - start=1 with load_len≠0 arms loading; start with load_len=0 goes straight to FETCH next cycle.
- LOAD, armed:
  - PMEM_LE=PMEM_E=1, rx_reset=0, busy=1.
  - Each rx_done increments the count.
  - The cycle the count reaches load_len, go to FETCH; count clears.
  - start while armed is ignored.
- FETCH (1 cycle): IR_E=PMEM_E=1; next state DECODE.
- DECODE:
  - If IR[13]=0 and IR[11:9]=001 (M-type): DR_E=DMEM_E=1, held for 1+DMEM_WAIT cycles, then EXECUTE.
  - Otherwise 1 cycle, then EXECUTE.
- EXECUTE, IR[13]=0 (1 cycle, then FETCH). Decode priority:
  - IR[11]=1: I-type. PC_E, Acc_E, SR_E, ALU_E, MUX1_Sel=1; MUX2_Sel=0; ALU_Mode={0,IR[10:8]}.
  - IR[10]=1: conditional branch. PC_E=1, MUX1_Sel=SR[IR[9:8]].
  - IR[9]=1: M-type. PC_E, SR_E, ALU_E, MUX1_Sel, MUX2_Sel=1; Acc_E=IR[8]; DMEM_E=DMEM_WE=~IR[8]; ALU_Mode=IR[7:4].
  - IR[8]=1: GOTO. PC_E=1, MUX1_Sel=0.
  - Otherwise special. PC_E=1, MUX1_Sel=1, COMP_E=IR[4].
- EXECUTE, IR[13:12]=11 (RX):
  - MUX3_sel, DMEM_E, DMEM_WE, MUX1_Sel=1; rx_reset=0; busy=1; PC_E=0.
  - In the cycle rx_PC_E=1: PC_E=1, next FETCH.
- EXECUTE, IR[13:12]=10 (TX):
  - DR_E, DMEM_E, tx_ready, MUX1_Sel=1; tx_reset=0; busy=1; PC_E=0.
  - In the cycle tx_done=1: PC_E=1, next FETCH.
- I/O timeout:
  - The timeout counter counts each RX/TX EXECUTE cycle without completion.
  - When it reaches IO_TIMEOUT: PC_E=1 (MUX1_Sel=1), io_timeout=1 for that cycle, counter clears, next FETCH.
  - Completion in the same cycle as the limit counts as normal completion; io_timeout=0.
- Counters saturate, never wrap.
- The load counter compares at full ADDR_W; load_len=2^ADDR_W-1 is legal.
- Reset mid-load or mid-I/O aborts immediately to the reset state; no partial PC update.

Optional Feature:
- Macro CTRL_SEQ_HALT_EN.
- Defined:
  - IR=14'h00FF is HALT. EXECUTE holds with PC_E=0, all enables 0.
  - Extra output port halted (1 bit) is 1 and stays so until rst_n.
  - start is ignored while halted.
- Undefined: no halted port; 14'h00FF decodes as a special instruction (PC_E=1, MUX1_Sel=1, COMP_E=1).

Test Plan:
- Reset, then start with load_len=3 and three rx_done pulses spaced 4 cycles apart -> PMEM_LE=1 throughout the load; stage=FETCH exactly one cycle after the 3rd pulse.
- IR=14'h0B00 (I-type, mode 3), DMEM_WAIT=2 -> FETCH, DECODE, EXECUTE (3 cycles); ALU_Mode=3; Acc_E=SR_E=PC_E=1 in EXECUTE.
- IR=14'h0230 (M-type to DMEM), DMEM_WAIT=2 -> DECODE lasts 3 cycles with DR_E=1; EXECUTE has DMEM_WE=1, Acc_E=0, ALU_Mode=3.
- IR=14'h0500 (conditional branch on SR[1]) with SR=4'b0010 -> MUX1_Sel=1; with SR=0 -> MUX1_Sel=0; PC_E=1 in both.
- IR=14'h2000 (TX) with tx_done after 5 cycles -> tx_ready high for 6 cycles, PC_E=1 only in the last; with no tx_done and IO_TIMEOUT=200 -> io_timeout pulses at cycle 200, then stage=FETCH.
- rst_n low during an RX wait -> all outputs at default immediately; stage=LOAD; no PC_E pulse.
